regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ requesters, e.g. writeback stage, multdiv completion, exception/status writer.
- Each requester uses a valid/ready handshake.
- Arbitration is round-robin. The winner is captured into a one-entry output stage that drives the regfile write port one cycle later.
- Sits between the pipeline back-end and the regfile write inputs (ctrl_writeEnable / ctrl_writeReg / data_writeReg).

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 5, register index width (32 registers)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  per-requester accept; handshake completes when valid & ready at a clock edge
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed destination index; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  NUM_REQ*DATA_WIDTH  packed write data, same packing scheme
- wr_block  in  1  regfile unavailable this cycle; no grants issued
- flush  in  1  synchronous cancel; see Behaviour
- ctrl_writeEnable  out  1  regfile write enable
- ctrl_writeReg  out  ADDR_WIDTH  regfile write index
- data_writeReg  out  DATA_WIDTH  regfile write data
- last_grant  out  NUM_REQ  one-hot; requester whose write is in the output stage (0 if none)

Behaviour:
- Reset while reset=0, asynchronous, takes effect mid-operation:
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, last_grant=0
  - RR pointer = 0, so requester 0 has highest priority first
  - any captured write is discarded
- req_ready is combinational. It is one-hot or zero: req_ready[i] = grant[i]. It never depends on the requester's own ready, only on valid.
- Grant, computed combinationally each cycle:
  - No grant when wr_block=1, flush=1, or no valid requests.
  - Otherwise grant the first valid requester at or after the RR pointer, in increasing index order, wrapping from NUM_REQ-1 to 0.
- RR pointer:
  - On a completed handshake by requester k, the pointer becomes (k+1) mod NUM_REQ.
  - Otherwise the pointer holds.
- Output stage, registered with latency 1:
  - At an edge with a grant to k: capture ctrl_writeReg=req_addr[k] and data_writeReg=req_data[k]; set last_grant=onehot(k).
  - ctrl_writeEnable = (req_addr[k] != 0). A write to register 0 is accepted and acknowledged but never asserts ctrl_writeEnable.
  - At an edge with no grant: ctrl_writeEnable=0 and last_grant=0. ctrl_writeReg and data_writeReg hold their previous values.
  - ctrl_writeEnable is high for exactly one cycle per granted nonzero-address write. Back-to-back grants give a continuous write every cycle (throughput 1/cycle).
- Flush:
  - No grant in the flush cycle.
  - At that edge, ctrl_writeEnable=0 and last_grant=0, so the write captured in the previous cycle still completes in the flush cycle; flush cancels nothing already on the port.
  - RR pointer is unchanged.
- wr_block: behaves like flush for grant purposes. The output stage clears at the next edge.
- Same-address collision (two requesters targeting one index in one cycle): only one is granted. The loser waits and is written later, so the later write wins in the regfile. No merging.
- Requester contract: while req_valid[i]=1 and not granted, addr and data must stay stable. A bench assertion checks this. The block itself does not buffer ungranted requests.
- No starvation: every continuously valid requester is granted within NUM_REQ cycles of no-block/no-flush operation.

Decomposition:
- Shared package regfile_pkg:
  - REG_COUNT=32 and REG_ADDR_W=5
  - DATA_W=32
  - ZERO_REG=5'd0, shared with the regfile read-side decode
- One natural sub-module: rr_arbiter (NUM_REQ parameter; inputs valid vector, pointer, enable; output one-hot grant). It is reusable for the multdiv result port.
- The output stage and pointer register stay in the top module, built from standard flops with asynchronous active-low clear.

Test Plan:
- Single requester: req_valid=001, addr=5'd3, data=32'hDEADBEEF → req_ready=001 same cycle; next cycle ctrl_writeEnable=1, ctrl_writeReg=3, data_writeReg=DEADBEEF, last_grant=001; following cycle enable=0.
- All three valid continuously from reset, addrs 1/2/3 → grant order 0,1,2,0,1,2; ctrl_writeEnable high every cycle from cycle 1; no requester waits more than 3 cycles.
- Register 0: requester 1 writes addr 0, data 32'h1234 → req_ready[1]=1, last_grant=010, ctrl_writeEnable stays 0; RR pointer advances to 2.
- Collision: req 0 and req 2 both target addr 7 with data 32'hA then 32'hB, pointer at 2 → req 2 written first (B), then req 0 (A); final regfile model holds 32'hA.
- wr_block=1 for 4 cycles with all requesters valid → req_ready=000 throughout; enable drops one cycle after block rises; grants resume at the held pointer when block falls.
- Asynchronous reset pulse mid-stream, between clock edges, while a write is on the port → ctrl_writeEnable, last_grant and the pointer go to 0 immediately; after release, requester 0 is granted first.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//
// Purpose : Constants and types shared by the register file and the logic that
//           feeds its write port.
//           ZERO_REG is the hard-wired zero register. The write arbiter uses it
//           to suppress the write enable. The regfile read-side decode uses it
//           to force reads of index 0 to zero.
//
// Contents: REG_COUNT, REG_ADDR_W, DATA_W, ZERO_REG, reg_addr_t, reg_data_t
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

endpackage : regfile_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Purpose : Purely combinational round-robin arbiter. It grants the first valid
//           requester at or after i_ptr, searching in increasing index order and
//           wrapping from NUM_REQ-1 back to 0. The pointer register lives in the
//           caller, so the caller decides when the pointer advances. This lets
//           the same block serve the regfile write port and the multdiv result
//           port.
//
// Ports   : i_valid     [NUM_REQ]  request vector
//           i_ptr       [PTR_W]    highest-priority index this cycle
//           i_enable               0 forces no grant (block / flush)
//           o_grant     [NUM_REQ]  one-hot grant, or zero
//           o_grant_idx [PTR_W]    binary index of the grant (0 if none)
//           o_grant_any            any grant issued this cycle
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [PTR_W-1:0]   i_ptr,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_grant_idx,
  output logic               o_grant_any
);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    // NOTE: every output of this block gets a default before any branch. A
    // path that skips an assignment would otherwise infer a latch.
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_any = 1'b0;
    w_idx       = '0;
    if (i_enable) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        // Candidate index, wrapped. It always stays below NUM_REQ, so it is
        // safe for widths that are not a power of two.
        w_idx = PTR_W'((int'(i_ptr) + off) % NUM_REQ);
        if (!o_grant_any && i_valid[w_idx]) begin
          o_grant[w_idx] = 1'b1;
          o_grant_idx    = w_idx;
          o_grant_any    = 1'b1;
        end
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose : Shares the single regfile write port between NUM_REQ requesters
//           (writeback, multdiv completion, exception/status writer). Each
//           requester uses a valid/ready handshake. Arbitration is round-robin.
//           The winner is captured into a one-entry output stage, which drives
//           ctrl_writeEnable / ctrl_writeReg / data_writeReg one cycle after the
//           handshake. The stage can accept a new write every cycle.
//
// Ports   : clock             rising-edge clock
//           reset             asynchronous active-low clear of all state
//           req_valid [N]     per-requester write request
//           req_ready [N]     per-requester accept (combinational, one-hot/0)
//           req_addr  [N*AW]  packed indices; requester i at [i*AW +: AW]
//           req_data  [N*DW]  packed write data, same packing
//           wr_block          regfile busy; no grant this cycle
//           flush             synchronous cancel; no grant this cycle
//           ctrl_writeEnable  regfile write enable (never for register 0)
//           ctrl_writeReg     regfile write index
//           data_writeReg     regfile write data
//           last_grant [N]    one-hot owner of the write now on the port
//
// Writes to ZERO_REG are accepted and acknowledged, but they never raise
// ctrl_writeEnable. When no grant is issued, the index and data registers hold
// their values. Only the enable and last_grant return to zero.
// -----------------------------------------------------------------------------
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          wr_block,
  input  logic                          flush,
  output logic                          ctrl_writeEnable,
  output logic [ADDR_WIDTH-1:0]         ctrl_writeReg,
  output logic [DATA_WIDTH-1:0]         data_writeReg,
  output logic [NUM_REQ-1:0]            last_grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // ---------------------------------------------------------------------------
  // Unpack the flat request buses so the winner can be selected by index.
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] w_req_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_req_data [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_addr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_req_data[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [NUM_REQ-1:0]    w_grant;
  logic [PTR_W-1:0]      w_grant_idx;
  logic                  w_grant_any;
  logic                  w_arb_enable;
  logic [PTR_W-1:0]      w_next_ptr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_writes;

  // Block and flush both suppress the grant in their own cycle. Neither one
  // touches the pointer.
  assign w_arb_enable = !wr_block && !flush;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .i_valid     (req_valid),
    .i_ptr       (r_rr_ptr),
    .i_enable    (w_arb_enable),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_grant_any (w_grant_any)
  );

  // A grant is only given to a valid requester, and ready equals grant.
  // So every grant is a completed handshake at the next edge.
  assign req_ready = w_grant;

  assign w_sel_addr   = w_req_addr[w_grant_idx];
  assign w_sel_data   = w_req_data[w_grant_idx];
  assign w_sel_writes = (w_sel_addr != ADDR_WIDTH'(ZERO_REG));

  // The winner gets the lowest priority next time.
  always_comb begin
    w_next_ptr = w_grant_idx + PTR_W'(1);
    if (w_grant_idx == PTR_W'(NUM_REQ - 1)) begin
      w_next_ptr = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
    end else if (w_grant_any) begin
      // NOTE: state registers use non-blocking assignments. All flops then
      // sample the pre-edge values and simulation matches the synthesized
      // hardware.
      r_rr_ptr <= w_next_ptr;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage (latency 1)
  // ---------------------------------------------------------------------------
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [NUM_REQ-1:0]    r_last_grant;

  // The enable and owner bits clear whenever no grant is issued.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_we         <= 1'b0;
      r_last_grant <= '0;
    end else if (w_grant_any) begin
      r_we         <= w_sel_writes;
      r_last_grant <= w_grant;
    end else begin
      r_we         <= 1'b0;
      r_last_grant <= '0;
    end
  end

  // Index and data hold when no grant is issued.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: these wide data-path registers would normally be left unreset,
      // since the enable qualifies them. They are cleared here because the
      // port values are visible to the regfile and must read zero after reset.
      r_addr <= '0;
      r_data <= '0;
    end else if (w_grant_any) begin
      r_addr <= w_sel_addr;
      r_data <= w_sel_data;
    end
  end

  assign ctrl_writeEnable = r_we;
  assign ctrl_writeReg    = r_addr;
  assign data_writeReg    = r_data;
  assign last_grant       = r_last_grant;

endmodule : regfile_write_arbiter
